wb_regfile: RTL and testbench

Write-back stage and general-purpose register file of the 5-stage MIPS pipeline. Consumes the MEM/WB pipeline register outputs: `wwreg`, `wm2reg`, `walu`, `wmo` and `wrn`. It selects the write-back value, commits it to a 32×32 register file, and serves two decode-stage read ports with same-cycle write-through bypass. It also counts committed register writes for the performance/debug path.

---
 rtl/mips_pkg.sv | 9 +
 rtl/wb_sel.sv | 31 +++
 rtl/wb_regfile.sv | 114 +++++++++++
 tb/tb_wb_regfile.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline.
// Holds the datapath and register-index widths and the hard-wired zero register index.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;

endpackage : mips_pkg

// File: rtl/wb_sel.sv
// Write-back value select.
// Picks memory read data for loads and the ALU result for everything else.
// The forwarding unit reuses this mux, so it has no side conditions such as
// a write enable.
// Ports:
//   wm2reg : 1 = take wmo, 0 = take walu
//   walu   : ALU result from MEM/WB
//   wmo    : memory read data from MEM/WB
//   wdi    : selected write-back value (combinational)
module wb_sel
  import mips_pkg::*;
#(
  parameter int DW = mips_pkg::DATA_W
) (
  input  logic          wm2reg,
  input  logic [DW-1:0] walu,
  input  logic [DW-1:0] wmo,
  output logic [DW-1:0] wdi
);

  // Write-back source mux.
  always_comb begin
    wdi = walu;
    if (wm2reg) begin
      wdi = wmo;
    end else begin
      wdi = walu;
    end
  end

endmodule : wb_sel

// File: rtl/wb_regfile.sv
// Write-back stage and general-purpose register file.
// Selects the write-back value, commits it to a 2^ADDR_W x DATA_W flop array,
// and serves two decode read ports. A read that hits the register being
// committed this cycle gets the new value directly (write-through bypass).
// A counter tracks committed writes, with a sticky wrap flag.
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   wwreg, wm2reg       : MEM/WB write enable and load select
//   walu, wmo, wrn      : MEM/WB ALU result, memory data, destination index
//   rna, rnb / qa, qb   : decode read port indices and data
//   wdi                 : selected write-back value, for the forwarding unit
//   commit_cnt          : number of committed register writes (wraps)
//   commit_ovf          : sticky, set when commit_cnt wraps
module wb_regfile #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wwreg,
  input  logic              wm2reg,
  input  logic [DATA_W-1:0] walu,
  input  logic [DATA_W-1:0] wmo,
  input  logic [ADDR_W-1:0] wrn,
  input  logic [ADDR_W-1:0] rna,
  input  logic [ADDR_W-1:0] rnb,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  output logic [DATA_W-1:0] wdi,
  output logic [CNT_W-1:0]  commit_cnt,
  output logic              commit_ovf
);

  import mips_pkg::*;

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] wdi_s;
  logic              commit_s;
  logic [DATA_W-1:0] regs_r [0:NREG-1];
  logic [CNT_W-1:0]  cnt_r;
  logic              ovf_r;

  wb_sel #(
    .DW(DATA_W)
  ) u_wb_sel (
    .wm2reg(wm2reg),
    .walu  (walu),
    .wmo   (wmo),
    .wdi   (wdi_s)
  );

  assign wdi = wdi_s;

  // Writes to the zero register are dropped entirely, including from the count.
  assign commit_s = wwreg && (wrn != ZERO_IDX);

  // Register array. Entry 0 is cleared by reset and never written, so it
  // stays zero and is trimmed by synthesis.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (commit_s) begin
      regs_r[wrn] <= wdi_s;
    end
  end

  // Commit counter and sticky wrap flag; the wrap edge is the one that
  // increments from all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (commit_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
      if (cnt_r == {CNT_W{1'b1}}) begin
        ovf_r <= 1'b1;
      end
    end
  end

  assign commit_cnt = cnt_r;
  assign commit_ovf = ovf_r;

  // Read port A. Reset forces zero so a bypass hit cannot leak wdi while the
  // array is being held clear.
  always_comb begin
    qa = {DATA_W{1'b0}};
    if (rst || (rna == ZERO_IDX)) begin
      qa = {DATA_W{1'b0}};
    end else if (commit_s && (rna == wrn)) begin
      qa = wdi_s;
    end else begin
      qa = regs_r[rna];
    end
  end

  // Read port B, same rules as port A.
  always_comb begin
    qb = {DATA_W{1'b0}};
    if (rst || (rnb == ZERO_IDX)) begin
      qb = {DATA_W{1'b0}};
    end else if (commit_s && (rnb == wrn)) begin
      qb = wdi_s;
    end else begin
      qb = regs_r[rnb];
    end
  end

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          wwreg;
  logic          wm2reg;
  logic [DW-1:0] walu;
  logic [DW-1:0] wmo;
  logic [AW-1:0] wrn;
  logic [AW-1:0] rna;
  logic [AW-1:0] rnb;
  logic [DW-1:0] qa;
  logic [DW-1:0] qb;
  logic [DW-1:0] wdi;
  logic [CW-1:0] commit_cnt;
  logic          commit_ovf;

  int n_tests;
  int n_fail;

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .wwreg(wwreg), .wm2reg(wm2reg),
    .walu(walu), .wmo(wmo), .wrn(wrn), .rna(rna), .rnb(rnb),
    .qa(qa), .qb(qb), .wdi(wdi),
    .commit_cnt(commit_cnt), .commit_ovf(commit_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wwreg;
    logic          wm2reg;
    logic [DW-1:0] walu;
    logic [DW-1:0] wmo;
    logic [AW-1:0] wrn;
    logic [AW-1:0] rna;
    logic [AW-1:0] rnb;
    logic [DW-1:0] exp_qa;   // before the edge
    logic [DW-1:0] exp_qb;   // before the edge
    logic [DW-1:0] exp_wdi;
    logic [CW-1:0] exp_cnt;  // after the edge
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [DW-1:0] a,
                       input logic [DW-1:0] m, input logic [AW-1:0] w,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    wwreg = we; wm2reg = m2r; walu = a; wmo = m; wrn = w; rna = ra; rnb = rb;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

    //                 we    m2r   walu          wmo           wrn     rna     rnb     qa            qb            wdi           cnt
    vecs[0]  = '{1'b1, 1'b0, 32'h12345678, 32'h00000000, 5'd5,  5'd5,  5'd0,  32'h12345678, 32'h00000000, 32'h12345678, 4'd1};
    vecs[1]  = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 5'd0,  5'd5,  5'd5,  32'h12345678, 32'h12345678, 32'h00000000, 4'd1};
    vecs[2]  = '{1'b1, 1'b1, 32'h11111111, 32'hDEADBEEF, 5'd9,  5'd9,  5'd9,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 4'd2};
    vecs[3]  = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 5'd0,  5'd9,  5'd5,  32'hDEADBEEF, 32'h12345678, 32'h00000000, 4'd2};
    vecs[4]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000000, 5'd0,  5'd0,  5'd0,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'd2};
    vecs[5]  = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 5'd0,  5'd0,  5'd9,  32'h00000000, 32'hDEADBEEF, 32'h00000000, 4'd2};
    vecs[6]  = '{1'b1, 1'b0, 32'h00000001, 32'h00000000, 5'd3,  5'd3,  5'd5,  32'h00000001, 32'h12345678, 32'h00000001, 4'd3};
    vecs[7]  = '{1'b0, 1'b0, 32'hAAAA5555, 32'h00000000, 5'd3,  5'd3,  5'd3,  32'h00000001, 32'h00000001, 32'hAAAA5555, 4'd3};
    vecs[8]  = '{1'b0, 1'b1, 32'h00000000, 32'h5A5A5A5A, 5'd3,  5'd3,  5'd3,  32'h00000001, 32'h00000001, 32'h5A5A5A5A, 4'd3};
    vecs[9]  = '{1'b1, 1'b0, 32'h0BADF00D, 32'h00000000, 5'd31, 5'd31, 5'd3,  32'h0BADF00D, 32'h00000001, 32'h0BADF00D, 4'd4};
    vecs[10] = '{1'b1, 1'b0, 32'hCAFE0001, 32'h00000000, 5'd31, 5'd31, 5'd30, 32'hCAFE0001, 32'h00000000, 32'hCAFE0001, 4'd5};
    vecs[11] = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 5'd0,  5'd31, 5'd0,  32'hCAFE0001, 32'h00000000, 32'h00000000, 4'd5};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", DW'(commit_cnt), 32'h0);
    chk("rst_ovf", DW'(commit_ovf), 32'h0);
    rst = 1'b0;

    // Table-driven main function.
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].wwreg, vecs[i].wm2reg, vecs[i].walu, vecs[i].wmo,
            vecs[i].wrn, vecs[i].rna, vecs[i].rnb);
      #2;
      chk($sformatf("v%0d_qa", i),  qa,  vecs[i].exp_qa);
      chk($sformatf("v%0d_qb", i),  qb,  vecs[i].exp_qb);
      chk($sformatf("v%0d_wdi", i), wdi, vecs[i].exp_wdi);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_cnt", i), DW'(commit_cnt), DW'(vecs[i].exp_cnt));
      chk($sformatf("v%0d_ovf", i), DW'(commit_ovf), 32'h0);
    end

    // Asynchronous reset between edges, with a bypass hit presented.
    drive(1'b1, 1'b0, 32'h77777777, 32'h0, 5'd9, 5'd9, 5'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("async_qa", qa, 32'h0);
    chk("async_qb", qb, 32'h0);
    chk("async_cnt", DW'(commit_cnt), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rna = AW'(i);
      rnb = AW'(31 - i);
      #1;
      chk($sformatf("clr_qa%0d", i), qa, 32'h0);
      chk($sformatf("clr_qb%0d", 31 - i), qb, 32'h0);
    end
    chk("clr_cnt", DW'(commit_cnt), 32'h0);
    chk("clr_ovf", DW'(commit_ovf), 32'h0);

    // Back-to-back writes to one register; counter wraps at 16 commits.
    @(posedge clk);
    #1;
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 1'b0, DW'(i) * 32'h00010001, 32'h0, 5'd7, 5'd7, 5'd0);
      #1;
      chk($sformatf("b2b_byp%0d", i), qa, DW'(i) * 32'h00010001);
      @(posedge clk);
      #1;
      chk($sformatf("wrap_cnt%0d", i), DW'(commit_cnt), DW'(i % 16));
      chk($sformatf("wrap_ovf%0d", i), DW'(commit_ovf), (i >= 16) ? 32'h1 : 32'h0);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
    #1;
    chk("b2b_last", qa, 32'h00110011);

    // Reset clears the wrapped state; commit held during reset does not count.
    drive(1'b1, 1'b0, 32'h00000042, 32'h0, 5'd4, 5'd4, 5'd7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2_cnt", DW'(commit_cnt), 32'h0);
    chk("rst2_ovf", DW'(commit_ovf), 32'h0);
    chk("rst2_qb", qb, 32'h0);
    // Deassert mid-cycle: the next edge is the first commit.
    #2;
    rst = 1'b0;
    #1;
    chk("rel_byp", qa, 32'h00000042);
    @(posedge clk);
    #1;
    chk("rel_cnt", DW'(commit_cnt), 32'h1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd7);
    #1;
    chk("rel_arr", qa, 32'h00000042);
    chk("rel_old", qb, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_wb_regfile
